pixel_queue: RTL

Buffers pixel-write requests from the CPU core and feeds them, one at a time, to the pixel writer that drives the graphics-memory write port. It holds every request until the pixel writer finishes its screen clear, then issues each pixel with a level handshake that never produces a duplicate write. It discards off-screen pixels (y ≥ 192) and counts them. It tells the CPU when all queued pixels have been written.

---
 rtl/pixel_queue_pkg.sv | 31 +++
 rtl/pixel_queue_if.sv | 31 +++
 rtl/pixel_fifo.sv | 84 ++++++++
 rtl/pixel_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pixel_queue_pkg.sv
// Shared definitions for the pixel request queue: screen geometry,
// issue-FSM state encoding and the packed request format.
package pixel_queue_pkg;

  // Visible screen height; rows at or beyond this are discarded.
  localparam int unsigned SCREEN_LINES = 192;

  // Width of one packed request {y, x, rgb}.
  localparam int unsigned REQ_W = 24;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_WAIT_CLEAR = 2'd0,
    ST_IDLE       = 2'd1,
    ST_PRESENT    = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_e;

  // One pixel request as stored in the FIFO.
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] rgb;
  } pix_req_t;

  // True when the row lies on the visible screen.
  function automatic logic on_screen(input logic [7:0] y);
    return (y < 8'(SCREEN_LINES));
  endfunction

endpackage

// File: rtl/pixel_queue_if.sv
// Bus bundle between the CPU request side, the pixel queue and the
// pixel writer. The queue uses the slave view; a CPU/writer model uses
// the master view.
interface pixel_queue_if;

  // CPU request side
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic [7:0] in_rgb;

  // Pixel writer side
  logic       clear_screen_done;
  logic       pixel_wr_done;
  logic       pixel_en;
  logic [7:0] pixel_x;
  logic [7:0] pixel_y;
  logic [7:0] pixel_rgb;

  modport slave (
    input  in_valid, in_x, in_y, in_rgb, clear_screen_done, pixel_wr_done,
    output in_ready, pixel_en, pixel_x, pixel_y, pixel_rgb
  );

  modport master (
    output in_valid, in_x, in_y, in_rgb, clear_screen_done, pixel_wr_done,
    input  in_ready, pixel_en, pixel_x, pixel_y, pixel_rgb
  );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO for packed pixel requests. Pointers wrap naturally at
// 2^DEPTH_LOG2; occupancy is tracked in a separate counter so that full
// and empty come straight from registers.
module pixel_fifo
  import pixel_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = REQ_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned           DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == CNT_ZERO);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Qualify requests against occupancy and compute next pointers/count.
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_queue.sv
// Pixel request queue: buffers CPU pixel writes, drops off-screen rows,
// and issues each pixel to the pixel writer with a level handshake.
// pixel_en is gated by pixel_wr_done so that the writer never sees the
// request still high on the edge where it returns to its accept state,
// and a completion only counts after pixel_en was seen high (WAIT_DONE),
// which filters out the writer's stale done level after screen clear.
module pixel_queue
  import pixel_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pixel_queue_if.slave        bus,
  output logic [DEPTH_LOG2:0] count_o,
  output logic                idle_o,
  output logic [7:0]          drop_count_o
);

  localparam logic [DEPTH_LOG2:0] CNT_ZERO = (DEPTH_LOG2+1)'(0);

  state_e              state_q;
  pix_req_t            out_q;
  logic [7:0]          drop_q, drop_d;

  pix_req_t            wr_data_s;
  logic [REQ_W-1:0]    rd_raw_s;
  pix_req_t            rd_data_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [DEPTH_LOG2:0] fifo_count_s;

  logic                accept_s;
  logic                push_s;
  logic                drop_s;
  logic                pop_s;
  logic                pixel_en_s;

  pixel_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (REQ_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_s),
    .wr_data_i (wr_data_s),
    .pop_i     (pop_s),
    .rd_data_o (rd_raw_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

  assign rd_data_s     = pix_req_t'(rd_raw_s);

  // in_ready follows rst_n directly so it is low throughout reset.
  assign bus.in_ready  = !fifo_full_s && rst_n;
  assign bus.pixel_en  = pixel_en_s;
  assign bus.pixel_x   = out_q.x;
  assign bus.pixel_y   = out_q.y;
  assign bus.pixel_rgb = out_q.rgb;
  assign count_o       = fifo_count_s;
  assign idle_o        = (state_q == ST_IDLE) && (fifo_count_s == CNT_ZERO);
  assign drop_count_o  = drop_q;

  // Classify an accepted request as a FIFO push or an off-screen drop.
  always_comb begin
    accept_s      = bus.in_valid && bus.in_ready;
    wr_data_s     = '0;
    wr_data_s.y   = bus.in_y;
    wr_data_s.x   = bus.in_x;
    wr_data_s.rgb = bus.in_rgb;
    if (on_screen(bus.in_y)) begin
      push_s = accept_s;
      drop_s = 1'b0;
    end else begin
      push_s = 1'b0;
      drop_s = accept_s;
    end
  end

  // Request level to the writer, masked while the writer reports done.
  always_comb begin
    pixel_en_s = 1'b0;
    case (state_q)
      ST_PRESENT,
      ST_WAIT_DONE: pixel_en_s = !bus.pixel_wr_done;
      default:      pixel_en_s = 1'b0;
    endcase
  end

  // Pop the head when idle, or when the in-flight write completes.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      ST_IDLE:      pop_s = !fifo_empty_s;
      ST_WAIT_DONE: pop_s = bus.pixel_wr_done && !fifo_empty_s;
      default:      pop_s = 1'b0;
    endcase
  end

  // Saturating count of discarded off-screen requests.
  always_comb begin
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Issue FSM together with the registered pixel data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_CLEAR;
      out_q   <= '0;
    end else begin
      case (state_q)
        ST_WAIT_CLEAR: begin
          if (bus.clear_screen_done) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            out_q   <= rd_data_s;
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (pixel_en_s) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.pixel_wr_done) begin
            if (!fifo_empty_s) begin
              out_q   <= rd_data_s;
              state_q <= ST_PRESENT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_WAIT_CLEAR;
        end
      endcase
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

endmodule
